// File: rtl/hline_zbuff_pkg.sv
// Shared types and encodings for the horizontal-line z-buffer burst controller.
package hline_zbuff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        INTERP,
        WR_Z,
        WR_FB,
        DONE
    } state_t;

    localparam logic [1:0] ZF_LESS   = 2'd0;
    localparam logic [1:0] ZF_LEQUAL = 2'd1;
    localparam logic [1:0] ZF_ALWAYS = 2'd2;
    localparam logic [1:0] ZF_NEVER  = 2'd3;

endpackage

// File: rtl/zinterp_step.sv
// Depth test plus exact integer-plus-remainder z stepper for one span.
module zinterp_step
    import hline_zbuff_pkg::*;
#(
    parameter int XW = 16,
    parameter int ZW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [ZW-1:0] z_start_i,
    input  logic [ZW-1:0] slope_i,
    input  logic [XW-1:0] rem_i,
    input  logic [XW-1:0] dx_i,
    input  logic [1:0]    zfunc_i,
    input  logic [ZW-1:0] zin_i,
    output logic          pass_o,
    output logic [ZW-1:0] zout_o
);

    logic [ZW-1:0] z_q, z_d;
    logic [XW-1:0] err_q, err_d;
    logic [XW:0]   e_sum, e_wrap;
    logic          carry;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pass_o = 1'b0;
        case (zfunc_i)
            ZF_LESS:   pass_o = (z_q < zin_i);
            ZF_LEQUAL: pass_o = (z_q <= zin_i);
            ZF_ALWAYS: pass_o = 1'b1;
            ZF_NEVER:  pass_o = 1'b0;
            default:   pass_o = 1'b0;
        endcase
        zout_o = pass_o ? z_q : zin_i;
    end

    // err stays below dx, so err + rem fits in XW+1 bits and one subtraction normalises it.
    always_comb begin
        e_sum  = {1'b0, err_q} + {1'b0, rem_i};
        e_wrap = e_sum - {1'b0, dx_i};
        carry  = (dx_i != '0) && (e_sum >= {1'b0, dx_i});
        err_d  = err_q;
        z_d    = z_q;
        if (load_i) begin
            err_d = '0;
            z_d   = z_start_i;
        end else if (step_i) begin
            err_d = carry ? e_wrap[XW-1:0] : e_sum[XW-1:0];
            z_d   = z_q + slope_i + {{(ZW-1){1'b0}}, carry};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!nreset) begin
            z_q   <= '0;
            err_q <= '0;
        end else begin
            z_q   <= z_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/hline_zbuff_burst_ctrl.sv
// Walks a horizontal span in bursts: z read, interpolate/depth-test, z write-back, frame write.
module hline_zbuff_burst_ctrl
    import hline_zbuff_pkg::*;
#(
    parameter int XW    = 16,
    parameter int ZW    = 32,
    parameter int AW    = 32,
    parameter int BURST = 256,
    parameter int LW    = $clog2(BURST) + 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [ZW-1:0] z_start,
    input  logic [ZW-1:0] slope,
    input  logic [XW-1:0] rem,
    input  logic [1:0]    zfunc,
    input  logic [AW-1:0] z_row_addr,
    input  logic [AW-1:0] fb_row_addr,
    output logic          busy,
    output logic          done,
    output logic          rd_req,
    input  logic          rd_ack,
    output logic          wr_req,
    output logic          wr_sel,
    input  logic          wr_done,
    output logic [AW-1:0] addr,
    output logic [LW-1:0] len,
    input  logic          zin_valid,
    input  logic [ZW-1:0] zin_data,
    output logic          zin_ready,
    output logic          zout_valid,
    output logic [ZW-1:0] zout_data,
    output logic          zout_be,
    input  logic          zout_full
);

    localparam int ZB = ZW / 8;

    state_t        state_q, state_d;
    logic [XW-1:0] xs_q, xs_d, dx_q, dx_d;
    logic [XW:0]   remaining_q, remaining_d;
    logic [LW-1:0] blen_q, blen_d, pcnt_q, pcnt_d, len_q, len_d;
    logic [1:0]    zfunc_q, zfunc_d;
    logic [AW-1:0] zrow_q, zrow_d, fbrow_q, fbrow_d, addr_q, addr_d;
    logic          accept, fire, pass;
    logic [ZW-1:0] zsel;

    assign accept = (state_q == IDLE) && start;
    assign fire   = (state_q == INTERP) && zin_valid && !zout_full;

    zinterp_step #(.XW(XW), .ZW(ZW)) u_step (
        .clk       (clk),
        .nreset    (nreset),
        .load_i    (accept),
        .step_i    (fire),
        .z_start_i (z_start),
        .slope_i   (slope),
        .rem_i     (rem),
        .dx_i      (dx_q),
        .zfunc_i   (zfunc_q),
        .zin_i     (zin_data),
        .pass_o    (pass),
        .zout_o    (zsel)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RD_REQ;
            RD_REQ:  if (rd_ack)  state_d = INTERP;
            INTERP:  if (fire && pcnt_q == LW'(1)) state_d = WR_Z;
            WR_Z:    if (wr_done) state_d = WR_FB;
            WR_FB:   if (wr_done) state_d = (remaining_q == (XW+1)'(blen_q)) ? DONE : RD_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xs_d        = xs_q;
        dx_d        = dx_q;
        remaining_d = remaining_q;
        pcnt_d      = pcnt_q;
        zfunc_d     = zfunc_q;
        zrow_d      = zrow_q;
        fbrow_d     = fbrow_q;
        case (state_q)
            IDLE: if (start) begin
                xs_d        = (x1 < x2) ? x1 : x2;
                dx_d        = (x1 < x2) ? (x2 - x1) : (x1 - x2);
                remaining_d = {1'b0, dx_d} + (XW+1)'(1);
                zfunc_d     = zfunc;
                zrow_d      = z_row_addr;
                fbrow_d     = fb_row_addr;
            end
            RD_REQ: if (rd_ack) pcnt_d = blen_q;
            INTERP: if (fire)   pcnt_d = pcnt_q - LW'(1);
            WR_FB: if (wr_done) begin
                xs_d        = xs_q + XW'(blen_q);
                remaining_d = remaining_q - (XW+1)'(blen_q);
            end
            default: ;
        endcase
        blen_d = (remaining_d > (XW+1)'(BURST)) ? LW'(BURST) : LW'(remaining_d);

        // addr/len are loaded on entry to each request state so they are stable for its whole duration.
        addr_d = addr_q;
        len_d  = len_q;
        case (state_d)
            RD_REQ, WR_Z: begin
                addr_d = zrow_d + AW'(xs_d) * AW'(ZB);
                len_d  = blen_d;
            end
            WR_FB: begin
                addr_d = fbrow_d + AW'(xs_d) * AW'(ZB);
                len_d  = blen_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            xs_q        <= '0;
            dx_q        <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            pcnt_q      <= '0;
            zfunc_q     <= '0;
            zrow_q      <= '0;
            fbrow_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
        end else begin
            xs_q        <= xs_d;
            dx_q        <= dx_d;
            remaining_q <= remaining_d;
            blen_q      <= blen_d;
            pcnt_q      <= pcnt_d;
            zfunc_q     <= zfunc_d;
            zrow_q      <= zrow_d;
            fbrow_q     <= fbrow_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        rd_req     = (state_q == RD_REQ);
        wr_req     = (state_q == WR_Z) || (state_q == WR_FB);
        wr_sel     = (state_q == WR_FB);
        zin_ready  = fire;
        zout_valid = fire;
        zout_be    = fire && pass;
        zout_data  = fire ? zsel : '0;
    end

    assign addr = addr_q;
    assign len  = len_q;

endmodule

// File: tb/tb_hline_zbuff_burst_ctrl.sv
// Randomised scoreboard bench: closed-form span model feeds expectation queues, monitors pop and compare.
module tb_hline_zbuff_burst_ctrl;

    localparam int XW = 16, ZW = 32, AW = 32, BURST = 256, LW = 9;

    logic          clk = 1'b0;
    logic          nreset;
    logic          start;
    logic [XW-1:0] x1, x2, rem;
    logic [ZW-1:0] z_start, slope, zin_data, zout_data;
    logic [1:0]    zfunc;
    logic [AW-1:0] z_row_addr, fb_row_addr, addr;
    logic [LW-1:0] len;
    logic          busy, done, rd_req, rd_ack, wr_req, wr_sel, wr_done;
    logic          zin_valid, zin_ready, zout_valid, zout_be, zout_full;

    always #5 clk = ~clk;

    hline_zbuff_burst_ctrl #(.XW(XW), .ZW(ZW), .AW(AW), .BURST(BURST), .LW(LW)) dut (
        .clk(clk), .nreset(nreset), .start(start), .x1(x1), .x2(x2),
        .z_start(z_start), .slope(slope), .rem(rem), .zfunc(zfunc),
        .z_row_addr(z_row_addr), .fb_row_addr(fb_row_addr),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_sel(wr_sel), .wr_done(wr_done),
        .addr(addr), .len(len), .zin_valid(zin_valid), .zin_data(zin_data),
        .zin_ready(zin_ready), .zout_valid(zout_valid), .zout_data(zout_data),
        .zout_be(zout_be), .zout_full(zout_full)
    );

    typedef struct { int kind; logic [31:0] addr; int len; int pix; } req_t;
    typedef struct { logic [31:0] data; logic be; } pix_t;

    req_t        exp_req[$];
    pix_t        exp_pix[$];
    logic [31:0] zin_src[$];
    logic [31:0] zin_fifo[$];

    int vectors = 0, miscompares = 0;
    int done_seen = 0, done_exp = 0, pix_seen = 0, pix_issued = 0;
    int stall_mode = 0;
    bit stray_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic ref_pass(input logic [1:0] f, input logic [31:0] z, input logic [31:0] zi);
        case (f)
            2'd0:    return z < zi;
            2'd1:    return z <= zi;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // zin_mode: 0 constant zc, 1 equal to the new z, 2 random, 3 within +-1 of the new z
    task automatic issue(input int a, input int b, input logic [31:0] z0, input logic [31:0] sl,
                         input int r, input logic [1:0] f, input int zin_mode, input logic [31:0] zc);
        int          xs, dx, x, left, bl, base;
        longint      acc;
        logic [31:0] zn, zi, zr, fr;
        pix_t        p;
        req_t        q;
        xs   = (a < b) ? a : b;
        dx   = (a < b) ? b - a : a - b;
        zr   = $urandom;
        fr   = $urandom;
        base = pix_issued;
        for (int i = 0; i <= dx; i++) begin
            acc = longint'(z0) + longint'($signed(sl)) * i + ((dx != 0) ? (longint'(r) * i) / dx : 0);
            zn  = acc[31:0];
            case (zin_mode)
                0:       zi = zc;
                1:       zi = zn;
                2:       zi = $urandom;
                default: zi = zn + 32'($urandom_range(0, 2)) - 32'd1;
            endcase
            zin_src.push_back(zi);
            p.be   = ref_pass(f, zn, zi);
            p.data = p.be ? zn : zi;
            exp_pix.push_back(p);
        end
        pix_issued += dx + 1;
        x    = xs;
        left = dx + 1;
        while (left > 0) begin
            bl = (left > BURST) ? BURST : left;
            q.len = bl;
            q.kind = 0; q.addr = zr + 32'(x) * 4; q.pix = base;      exp_req.push_back(q);
            q.kind = 1;                           q.pix = base + bl; exp_req.push_back(q);
            q.kind = 2; q.addr = fr + 32'(x) * 4;                    exp_req.push_back(q);
            base += bl;
            x    += bl;
            left -= bl;
        end
        @(posedge clk); #1;
        x1 = 16'(a); x2 = 16'(b); z_start = z0; slope = sl; rem = 16'(r);
        zfunc = f; z_row_addr = zr; fb_row_addr = fr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic flush();
        exp_pix.delete(); exp_req.delete(); zin_src.delete(); zin_fifo.delete();
        pix_issued = pix_seen;
    endtask

    task automatic run_cmd(input int a, input int b, input logic [31:0] z0, input logic [31:0] sl,
                           input int r, input logic [1:0] f, input int zin_mode, input logic [31:0] zc);
        int budget, cyc;
        budget = 10 * (((a < b) ? b - a : a - b) + 1) + 400;
        issue(a, b, z0, sl, r, f, zin_mode, zc);
        done_exp++;
        cyc = 0;
        while (done_seen < done_exp && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check("done_count", done_seen, done_exp);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("pixels_left", exp_pix.size(), 0);
        check("requests_left", exp_req.size(), 0);
        check("zin_left", zin_fifo.size() + zin_src.size(), 0);
        flush();
    endtask

    // Output-stream monitor
    initial begin : mon_pix
        pix_t p;
        forever begin
            @(negedge clk);
            if (nreset && zout_valid) begin
                check("zin_ready_with_valid", zin_ready, 1);
                check("zout_only_when_input_ok", zin_valid && !zout_full, 1);
                check("pixel_expected", exp_pix.size() > 0, 1);
                if (exp_pix.size() > 0) begin
                    p = exp_pix.pop_front();
                    check("zout_data", zout_data, p.data);
                    check("zout_be", zout_be, p.be);
                end
                pix_seen++;
            end else if (nreset) begin
                check("zin_ready_without_valid", zin_ready, 0);
            end
        end
    end

    initial begin : mon_done
        forever begin
            @(negedge clk);
            if (nreset && done) begin
                check("done_expected", done_seen < done_exp, 1);
                done_seen++;
            end
        end
    end

    // Memory-side responder: checks each burst request, then acknowledges after a random delay
    initial begin : responder
        req_t        r;
        int          kind, d;
        logic [31:0] a0;
        logic [LW-1:0] l0;
        rd_ack  = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (nreset && (rd_req || wr_req)) begin
                kind = rd_req ? 0 : (wr_sel ? 2 : 1);
                check("req_exclusive", rd_req && wr_req, 0);
                check("req_expected", exp_req.size() > 0, 1);
                if (exp_req.size() > 0) begin
                    r = exp_req.pop_front();
                    check("req_kind", kind, r.kind);
                    check("req_addr", addr, r.addr);
                    check("req_len", len, r.len);
                    check("req_pixel_order", pix_seen, r.pix);
                end
                a0 = addr;
                l0 = len;
                d  = $urandom_range(0, 3);
                repeat (d) begin
                    @(negedge clk);
                    if (nreset) begin
                        check("req_held", rd_req || wr_req, 1);
                        check("addr_stable", addr, a0);
                        check("len_stable", len, l0);
                    end
                end
                @(posedge clk); #1;
                if (kind == 0) begin
                    rd_ack = 1'b1;
                    for (int i = 0; i < int'(l0) && zin_src.size() > 0; i++)
                        zin_fifo.push_back(zin_src.pop_front());
                end else begin
                    wr_done = 1'b1;
                end
                @(posedge clk); #1;
                rd_ack  = 1'b0;
                wr_done = 1'b0;
            end else if (stray_en && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 1) == 0) rd_ack = 1'b1;
                else                           wr_done = 1'b1;
                @(posedge clk); #1;
                rd_ack  = 1'b0;
                wr_done = 1'b0;
            end
        end
    end

    // Read-FIFO / z-out-FIFO model with selectable back-pressure
    initial begin : fifo_drv
        bit pop;
        int phase, full_cnt;
        phase     = 0;
        full_cnt  = 0;
        zin_valid = 1'b0;
        zin_data  = '0;
        zout_full = 1'b0;
        forever begin
            @(negedge clk);
            pop = zin_valid && zin_ready;
            @(posedge clk); #1;
            if (pop && zin_fifo.size() > 0) void'(zin_fifo.pop_front());
            phase++;
            case (stall_mode)
                0: begin
                    zin_valid = (zin_fifo.size() > 0) && ($urandom_range(0, 3) != 0);
                    zout_full = ($urandom_range(0, 7) == 0);
                end
                1: begin
                    zin_valid = (zin_fifo.size() > 0) && (phase % 2 == 0);
                    if (phase % 16 == 5) full_cnt = 3;
                    zout_full = (full_cnt > 0);
                    if (full_cnt > 0) full_cnt--;
                end
                default: begin
                    zin_valid = (zin_fifo.size() > 0);
                    zout_full = 1'b0;
                end
            endcase
            zin_data = (zin_fifo.size() > 0) ? zin_fifo[0] : '0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        start = 1'b0; x1 = '0; x2 = '0; z_start = '0; slope = '0; rem = '0;
        zfunc = '0; z_row_addr = '0; fb_row_addr = '0;
        nreset = 1'b1;
        #1 nreset = 1'b0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_rd_req", rd_req, 0);
        check("reset_wr_req", wr_req, 0);
        check("reset_addr", addr, 0);
        check("reset_len", len, 0);
        check("reset_zout_valid", zout_valid, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        // basic span, then fractional step, then three-burst span
        stall_mode = 2;
        run_cmd(10, 13, 32'd100, 32'd5, 0, 2'd0, 0, 32'd200);
        run_cmd(0, 2, 32'd7, 32'd0, 1, 2'd0, 0, 32'hFFFF_FFFF);
        stall_mode = 0;
        run_cmd(599, 0, $urandom, $urandom_range(0, 200) - 100, $urandom_range(0, 598), 2'd0, 2, 0);

        // depth-test functions on equal and random inputs
        run_cmd(40, 60, 32'd1000, 32'hFFFF_FFFD, 7, 2'd1, 1, 0);
        run_cmd(60, 40, 32'd1000, 32'd3, 7, 2'd0, 1, 0);
        run_cmd(5, 30, $urandom, $urandom, 11, 2'd3, 2, 0);
        run_cmd(30, 5, $urandom, $urandom, 11, 2'd2, 2, 0);
        run_cmd(100, 150, 32'hFFFF_FFF0, 32'd1, 49, 2'd1, 3, 0);

        // heavy back-pressure
        stall_mode = 1;
        run_cmd(200, 233, 32'd50, 32'd2, 13, 2'd0, 3, 0);

        // exactly two full bursts
        stall_mode = 2;
        run_cmd(1000, 1511, $urandom, 32'd4, 300, 2'd2, 2, 0);

        // stray strobes while idle are ignored
        stray_en = 1'b1;
        repeat (16) @(posedge clk);
        stray_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_rd_req", rd_req, 0);
        check("stray_wr_req", wr_req, 0);

        // reset in the middle of INTERP abandons the span without done
        stall_mode = 0;
        issue(100, 400, 32'd9, 32'd1, 0, 2'd2, 2, 0);
        cyc = 0;
        while (pix_seen < pix_issued - 281 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("reached_interp", pix_seen >= pix_issued - 281, 1);
        @(posedge clk); #2;
        nreset = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_rd_req", rd_req, 0);
        check("midreset_wr_req", wr_req, 0);
        check("midreset_zout_valid", zout_valid, 0);
        check("midreset_zin_ready", zin_ready, 0);
        check("midreset_zout_data", zout_data, 0);
        check("midreset_addr", addr, 0);
        check("midreset_len", len, 0);
        repeat (10) @(posedge clk);
        flush();
        @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(posedge clk);
        check("no_done_after_reset", done_seen, done_exp);
        run_cmd(5, 5, 32'd77, $urandom, 0, 2'd0, 0, 32'd78);

        // randomised spans
        for (int k = 0; k < 8; k++) begin
            int a, dx, b, r;
            a  = $urandom_range(700, 3000);
            dx = $urandom_range(0, 700);
            b  = ($urandom_range(0, 1) == 1) ? a + dx : a - dx;
            r  = (dx > 0) ? $urandom_range(0, dx - 1) : 0;
            stall_mode = $urandom_range(0, 2);
            run_cmd(a, b, $urandom, $urandom, r, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom);
        end

        check("final_done_count", done_seen, done_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hline_zbuff_burst_ctrl.md
Name: hline_zbuff_burst_ctrl

Overview:
Parametrised successor to the single-burst horizontal-line z-buffer sequencer. It walks one horizontal span from min(x1,x2) to max(x1,x2) inclusive, in bursts of up to BURST pixels. For each burst it:
- requests a z-buffer read;
- interpolates z with an exact integer-plus-remainder stepper;
- applies a selectable depth-test function and emits new z words plus a per-pixel byte-enable bit;
- sequences the z-buffer write-back, then the frame-buffer write.

It sits between the register file/command front end and the AXI burst master plus its FIFOs.

Parameters:
- XW, 16, pixel coordinate width.
- ZW, 32, depth word width; also the pixel size in memory (ZW/8 bytes).
- AW, 32, byte address width.
- BURST, 256, maximum pixels per burst; power of two, ≥2.
- LW, $clog2(BURST)+1, burst length field width.

Ports:
- clk, in, 1, clock.
- nreset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle command strobe; sampled only in IDLE.
- x1, in, XW, span endpoint 1.
- x2, in, XW, span endpoint 2.
- z_start, in, ZW, z at the left endpoint min(x1,x2).
- slope, in, ZW, signed integer part of dz/dx, left-to-right.
- rem, in, XW, fractional numerator; 0 ≤ rem < dx.
- zfunc, in, 2, depth test: 0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER.
- z_row_addr, in, AW, byte address of z-buffer row start.
- fb_row_addr, in, AW, byte address of frame-buffer row start.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse at span completion.
- rd_req, out, 1, burst read request; held until rd_ack.
- rd_ack, in, 1, read request accepted.
- wr_req, out, 1, burst write request; held until wr_done.
- wr_sel, out, 1, 0 = z-buffer write, 1 = frame-buffer write.
- wr_done, in, 1, write burst complete.
- addr, out, AW, burst byte address.
- len, out, LW, burst length in pixels.
- zin_valid, in, 1, read FIFO not empty.
- zin_data, in, ZW, existing z from the read FIFO.
- zin_ready, out, 1, pop the read FIFO.
- zout_valid, out, 1, push to the z-out FIFO and the BE FIFO.
- zout_data, out, ZW, z to write: new z if the test passes, otherwise existing z.
- zout_be, out, 1, depth-test pass bit.
- zout_full, in, 1, z-out or BE FIFO full.

Behaviour:
- Reset (asynchronous, nreset=0): state IDLE; all outputs 0; internal registers 0. Reset mid-burst abandons the span immediately, with no done pulse.
- IDLE, start=1 latches:
  - xs = min(x1,x2);
  - dx = |x1−x2|;
  - remaining = dx+1;
  - z = z_start, err = 0;
  - zfunc and the row addresses.
  - Then go to RD_REQ. start in any other state is ignored.
- RD_REQ:
  - blen = min(BURST, remaining);
  - addr = z_row_addr + xs·(ZW/8), len = blen, rd_req=1.
  - On rd_ack go to INTERP, with pcnt = blen.
- INTERP, one pixel per cycle when zin_valid && !zout_full; otherwise stall with no state change:
  - zin_ready = zout_valid = 1.
  - pass is decided per zfunc:
    - LESS: z < zin_data, unsigned.
    - LEQUAL: z ≤ zin_data, unsigned.
    - ALWAYS: 1.
    - NEVER: 0.
  - zout_be = pass; zout_data = pass ? z : zin_data.
  - Step: e = err + rem, with err ≤ dx so the sum never overflows (XW+1 bits).
    - If e ≥ dx and dx ≠ 0: err = e − dx, z = z + slope + 1.
    - Otherwise: err = e, z = z + slope.
    - z arithmetic wraps modulo 2^ZW.
  - pcnt decrements. On the last pixel (pcnt = 1 being consumed), go to WR_Z.
- WR_Z: wr_req=1, wr_sel=0, addr = z_row_addr + xs·(ZW/8), len = blen. On wr_done go to WR_FB.
- WR_FB: wr_req=1, wr_sel=1, addr = fb_row_addr + xs·(ZW/8), len = blen. On wr_done:
  - xs += blen; remaining −= blen;
  - if remaining = 0 go to DONE, else go to RD_REQ.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Stray strobes: rd_ack or wr_done outside its own state is ignored. A wr_done coincident with entry to WR_Z or WR_FB is not counted; only cycles already in the state count.
- busy = (state ≠ IDLE).
- addr and len are registered and stable while rd_req or wr_req is high.
- dx = 0: single pixel, one burst of len 1, no fractional step.
- Span exactly k·BURST: k full bursts, no zero-length burst.
- xs overflow past 2^XW−1 is not checked; the caller guarantees valid endpoints.

Decomposition:
- Package hline_zbuff_pkg holds:
  - the state enum (IDLE, RD_REQ, INTERP, WR_Z, WR_FB, DONE);
  - the zfunc encodings ZF_LESS, ZF_LEQUAL, ZF_ALWAYS, ZF_NEVER.
- Sub-module zinterp_step: the combinational depth test plus the registered z/err accumulator, with load, step and stall controls. The controller instantiates it once.

Test Plan:
1. x1=10, x2=13, z_start=100, slope=5, rem=0, zfunc=LESS, all zin=200 → rd addr=z_row+40, len=4; zout 100,105,110,115, all be=1; WR_Z then WR_FB len=4; done pulse.
2. x1=0, x2=2, slope=0, rem=1 (dx=2), z_start=7 → z sequence 7,7,8; err 1,0,1.
3. x1=599, x2=0, BURST=256 → three bursts: len 256 at x 0, len 256 at x 256, len 88 at x 512; each burst completes RD, INTERP, WR_Z, WR_FB in order; one done at the end.
4. zfunc LEQUAL with zin equal to z → be=1; LESS with zin equal → be=0 and zout_data=zin; NEVER → all be=0; ALWAYS → all be=1.
5. zin_valid toggles low every other cycle and zout_full asserts for 3 cycles → zin_ready and zout_valid drop; z and pcnt hold; the output sequence is unchanged.
6. nreset asserted during INTERP → outputs 0 asynchronously, with no done; a fresh start with x1=x2=5 gives a single len-1 burst.
